// File: rtl/load_store_bank.sv
// load_store_bank
// ---------------------------------------------------------------------------
// Bank of NCH independent level counters. Each channel ramps its level from 0
// up to TOP in increments of STEP. It holds TOP for 1 + DWELL active cycles and
// then leaves TOP in one of two ways:
//   - triangle mode (saw = 0): it ramps back down to 0;
//   - sawtooth mode (saw = 1): it restarts from 0.
// Each channel has its own advance enable. Each channel also produces a
// one-cycle peak pulse and keeps a saturating count of its peaks.
//
// Ports
//   clk    in   1            clock
//   rst    in   1            synchronous active-high reset
//   en     in   NCH          per-channel advance enable (0 freezes the channel)
//   saw    in   1            0 = triangle, 1 = sawtooth (sampled when leaving TOP)
//   vol    out  NCH*CBITS    channel i level on [i*CBITS +: CBITS]
//   dir    out  NCH          1 unless the channel is ramping down
//   sig    out  NCH          vol_i == TOP
//   peak   out  NCH          one-cycle pulse when vol_i first reaches TOP
//   peaks  out  NCH*PBITS    saturating count of peak pulses per channel
// ---------------------------------------------------------------------------
module load_store_bank #(
  parameter int NCH   = 4,
  parameter int CBITS = 19,
  parameter int TOP   = 400000,
  parameter int STEP  = 1,
  parameter int DWELL = 0,
  parameter int PBITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         en,
  input  logic                   saw,
  output logic [NCH*CBITS-1:0]   vol,
  output logic [NCH-1:0]         dir,
  output logic [NCH-1:0]         sig,
  output logic [NCH-1:0]         peak,
  output logic [NCH*PBITS-1:0]   peaks
);

  // The dwell counter must be able to hold DWELL. It is kept at least 1 bit
  // wide, so that DWELL = 0 still gives a legal vector.
  localparam int DWB = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

  localparam logic [CBITS-1:0] TOP_V   = CBITS'(TOP);
  localparam logic [CBITS-1:0] STEP_V  = CBITS'(STEP);
  localparam logic [DWB-1:0]   DWELL_V = DWB'(DWELL);
  localparam logic [PBITS-1:0] PMAX    = {PBITS{1'b1}};

  typedef enum logic [1:0] {
    ST_UP   = 2'd0,
    ST_HOLD = 2'd1,
    ST_DOWN = 2'd2
  } ch_state_t;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      ch_state_t        state_reg, state_next;
      logic [CBITS-1:0] vol_reg,   vol_next;
      logic [DWB-1:0]   dwell_reg, dwell_next;
      logic [PBITS-1:0] peaks_reg, peaks_next;
      logic             sig_reg,   sig_next;
      logic             peak_reg,  peak_next;
      logic             dir_reg,   dir_next;
      logic [CBITS:0]   sum_up;

      // The sum is one bit wider than vol, so the TOP comparison cannot wrap.
      assign sum_up = {1'b0, vol_reg} + {1'b0, STEP_V};

      always_comb begin
        state_next = state_reg;
        vol_next   = vol_reg;
        dwell_next = dwell_reg;
        peaks_next = peaks_reg;
        peak_next  = 1'b0;

        if (en[gi]) begin
          case (state_reg)
            ST_UP: begin
              if (sum_up >= {1'b0, TOP_V}) begin
                // Clamp to TOP. Every TOP visit goes through HOLD. With
                // DWELL = 0 the counter is already 0, so the next active
                // cycle leaves TOP.
                vol_next   = TOP_V;
                peak_next  = 1'b1;
                state_next = ST_HOLD;
                dwell_next = DWELL_V;
                if (peaks_reg != PMAX) begin
                  peaks_next = peaks_reg + PBITS'(1);
                end
              end else begin
                vol_next = sum_up[CBITS-1:0];
              end
            end
            ST_HOLD: begin
              if (dwell_reg == '0) begin
                // Leave TOP. The mode is taken from saw at this moment.
                if (saw) begin
                  vol_next   = '0;
                  state_next = ST_UP;
                end else begin
                  vol_next   = TOP_V - STEP_V;
                  state_next = ST_DOWN;
                end
              end else begin
                dwell_next = dwell_reg - DWB'(1);
              end
            end
            ST_DOWN: begin
              if (vol_reg <= STEP_V) begin
                vol_next   = '0;
                state_next = ST_UP;
              end else begin
                vol_next = vol_reg - STEP_V;
              end
            end
            default: begin
              vol_next   = '0;
              state_next = ST_UP;
              dwell_next = '0;
            end
          endcase
        end

        // These flags are computed from the next level and state, so each
        // registered flag describes the vol it is registered with.
        sig_next = (vol_next == TOP_V);
        dir_next = (state_next != ST_DOWN);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= ST_UP;
          vol_reg   <= '0;
          dwell_reg <= '0;
          peaks_reg <= '0;
          sig_reg   <= 1'b0;
          peak_reg  <= 1'b0;
          dir_reg   <= 1'b1;
        end else begin
          state_reg <= state_next;
          vol_reg   <= vol_next;
          dwell_reg <= dwell_next;
          peaks_reg <= peaks_next;
          sig_reg   <= sig_next;
          peak_reg  <= peak_next;
          dir_reg   <= dir_next;
        end
      end

      assign vol[gi*CBITS +: CBITS]   = vol_reg;
      assign peaks[gi*PBITS +: PBITS] = peaks_reg;
      assign sig[gi]                  = sig_reg;
      assign peak[gi]                 = peak_reg;
      assign dir[gi]                  = dir_reg;
    end
  endgenerate

endmodule

// File: tb/tb_load_store_bank.sv
// tb_load_store_bank
// Directed bench for load_store_bank. It uses three instances that share the
// clock, reset, enable and mode signals:
//   dut_a: TOP=10, STEP=3, DWELL=2
//   dut_b: TOP=10, STEP=3, DWELL=0
//   dut_c: TOP=2,  STEP=1, DWELL=0
// Every expected value is hand-computed.
module tb_load_store_bank;

  logic        clk;
  logic        rst;
  logic [1:0]  en;
  logic        saw;

  logic [15:0] vol_a, vol_b;
  logic [7:0]  vol_c;
  logic [1:0]  dir_a, dir_b, dir_c;
  logic [1:0]  sig_a, sig_b, sig_c;
  logic [1:0]  peak_a, peak_b, peak_c;
  logic [15:0] peaks_a, peaks_b, peaks_c;

  int checks = 0;
  int errors = 0;

  load_store_bank #(.NCH(2), .CBITS(8), .TOP(10), .STEP(3), .DWELL(2), .PBITS(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .saw(saw),
    .vol(vol_a), .dir(dir_a), .sig(sig_a), .peak(peak_a), .peaks(peaks_a)
  );

  load_store_bank #(.NCH(2), .CBITS(8), .TOP(10), .STEP(3), .DWELL(0), .PBITS(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .saw(saw),
    .vol(vol_b), .dir(dir_b), .sig(sig_b), .peak(peak_b), .peaks(peaks_b)
  );

  load_store_bank #(.NCH(2), .CBITS(4), .TOP(2), .STEP(1), .DWELL(0), .PBITS(8)) dut_c (
    .clk(clk), .rst(rst), .en(en), .saw(saw),
    .vol(vol_c), .dir(dir_c), .sig(sig_c), .peak(peak_c), .peaks(peaks_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // One clock edge. Inputs are changed and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int tri_v[11]  = '{3, 6, 9, 10, 10, 10, 7, 4, 1, 0, 3};
  int tri_pk[11] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
  int tri_sg[11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
  int tri_dr[11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
  int nod_v[9]   = '{3, 6, 9, 10, 7, 4, 1, 0, 3};
  int nod_sg[9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
  int saw_v[14]  = '{3, 6, 9, 10, 10, 10, 0, 3, 6, 9, 10, 10, 10, 0};
  int en_seq[9]  = '{3, 2, 2, 3, 3, 1, 1, 3, 3};
  int st_v0[9]   = '{3, 3, 3, 6, 9, 10, 10, 10, 7};
  int st_v1[9]   = '{3, 6, 9, 10, 10, 10, 10, 10, 7};
  int st_p1[9]   = '{0, 0, 0, 1, 0, 0, 0, 0, 0};

  int max_c;

  initial begin
    rst = 1'b1;
    en  = 2'b00;
    saw = 1'b0;

    // Reset state. The enable is high during reset to show that reset dominates.
    en = 2'b11;
    do_reset();
    check("rst_vol_a", 32'(vol_a), 0);
    check("rst_dir_a", 32'(dir_a), 3);
    check("rst_sig_a", 32'(sig_a), 0);
    check("rst_peak_a", 32'(peak_a), 0);
    check("rst_peaks_a", 32'(peaks_a), 0);

    // Triangle, DWELL=2 (dut_a) and DWELL=0 (dut_b).
    for (int i = 0; i < 11; i++) begin
      step();
      check($sformatf("tri_vol0[%0d]", i), 32'(vol_a[7:0]), 32'(tri_v[i]));
      check($sformatf("tri_peak0[%0d]", i), 32'(peak_a[0]), 32'(tri_pk[i]));
      check($sformatf("tri_sig0[%0d]", i), 32'(sig_a[0]), 32'(tri_sg[i]));
      check($sformatf("tri_dir0[%0d]", i), 32'(dir_a[0]), 32'(tri_dr[i]));
      if (i < 9) begin
        check($sformatf("nod_vol0[%0d]", i), 32'(vol_b[7:0]), 32'(nod_v[i]));
        check($sformatf("nod_sig0[%0d]", i), 32'(sig_b[0]), 32'(nod_sg[i]));
      end
    end
    check("tri_peaks0", 32'(peaks_a[7:0]), 1);
    check("tri_vol1", 32'(vol_a[15:8]), 3);

    // Sawtooth, DWELL=2.
    saw = 1'b1;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step();
      check($sformatf("saw_vol0[%0d]", i), 32'(vol_a[7:0]), 32'(saw_v[i]));
      if (i == 6) check("saw_peaks0_p1", 32'(peaks_a[7:0]), 1);
      if (i == 13) check("saw_peaks0_p2", 32'(peaks_a[7:0]), 2);
    end

    // Per-channel enable stalls, including a stall during HOLD on channel 1.
    saw = 1'b0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      en = 2'(en_seq[i]);
      step();
      check($sformatf("stall_vol0[%0d]", i), 32'(vol_a[7:0]), 32'(st_v0[i]));
      check($sformatf("stall_vol1[%0d]", i), 32'(vol_a[15:8]), 32'(st_v1[i]));
      check($sformatf("stall_peak1[%0d]", i), 32'(peak_a[1]), 32'(st_p1[i]));
    end
    en = 2'b11;

    // Reset applied in the middle of the DOWN ramp.
    do_reset();
    for (int i = 0; i < 7; i++) step();
    check("mid_down_vol0", 32'(vol_a[7:0]), 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_vol0", 32'(vol_a[7:0]), 0);
    check("mid_rst_dir0", 32'(dir_a[0]), 1);
    check("mid_rst_peaks0", 32'(peaks_a[7:0]), 0);
    step();
    check("mid_rst_after_vol0", 32'(vol_a[7:0]), 3);

    // Peak counter saturation on dut_c (period 4, so 255 peaks by cycle 1020).
    do_reset();
    max_c = 0;
    for (int i = 0; i < 1200; i++) begin
      step();
      if (int'(vol_c[3:0]) > max_c) max_c = int'(vol_c[3:0]);
      if (i == 3)    check("sat_peaks0_early", 32'(peaks_c[7:0]), 1);
      if (i == 1099) check("sat_peaks0_1100", 32'(peaks_c[7:0]), 255);
    end
    check("sat_peaks0_end", 32'(peaks_c[7:0]), 255);
    check("sat_peaks1_end", 32'(peaks_c[15:8]), 255);
    check("sat_vol_max", 32'(max_c), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
